// File: rtl/pc_fetch_ctrl.sv
// PC owner and branch-resolution controller: fetch handshake, next-PC select, branch statistics.
// Optional macro PC_MISALIGN_EN: trap on misaligned targets instead of forcing word alignment.
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    output logic [31:0]      o_pc,
    output logic [31:0]      o_pc_four,
    output logic             o_imem_req,
    input  logic             i_imem_ack,
    input  logic             i_is_branch,
    input  logic             i_is_jal,
    input  logic             i_is_jalr,
    input  logic [2:0]       i_funct3,
    input  logic [31:0]      i_imm,
    input  logic [31:0]      i_rs1_data,
    output logic             o_br_un,
    input  logic             i_br_less,
    input  logic             i_br_equal,
    input  logic             i_hold,
    output logic             o_commit,
    output logic             o_taken,
    output logic [CNT_W-1:0] o_br_cnt,
    output logic [CNT_W-1:0] o_taken_cnt,
    output logic             o_misalign
);

    // state | meaning
    // IDLE  | one cycle after reset before the first fetch
    // FETCH | o_imem_req high, waiting for i_imem_ack
    // EXEC  | decode/comparator inputs valid; commit unless i_hold
    // TRAP  | misaligned target seen, parked until reset (PC_MISALIGN_EN only)
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2
`ifdef PC_MISALIGN_EN
        ,TRAP = 2'd3
`endif
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic [31:0]       pc_q;
    logic [CNT_W-1:0]  br_cnt_q, taken_cnt_q;
    logic              br_cond, br_taken, redirect, pc_load;
    logic [31:0]       target, next_pc;

    assign br_taken = i_is_branch & br_cond;
    assign redirect = i_is_jal | i_is_jalr | br_taken;

    always_comb begin
        br_cond = 1'b0;
        case (i_funct3)
            3'b000:         br_cond = i_br_equal;
            3'b001:         br_cond = ~i_br_equal;
            3'b100, 3'b110: br_cond = i_br_less;
            3'b101, 3'b111: br_cond = ~i_br_less;
            default:        br_cond = 1'b0;
        endcase
    end

    always_comb begin
        if (i_is_jalr)
            target = (i_rs1_data + i_imm) & ~32'h1;
        else if (i_is_jal || br_taken)
            target = pc_q + i_imm;
        else
            target = pc_q + 32'd4;
    end

`ifdef PC_MISALIGN_EN
    logic misalign_hit;
    assign misalign_hit = |target[1:0];
    assign next_pc      = target;
    assign o_misalign   = (state_q == TRAP);
`else
    assign next_pc    = target & ~32'h3;
    assign o_misalign = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        o_imem_req = 1'b0;
        o_commit   = 1'b0;
        o_taken    = 1'b0;
        pc_load    = 1'b0;
        case (state_q)
            IDLE:  state_d = FETCH;
            FETCH: begin
                o_imem_req = 1'b1;
                if (i_imem_ack)
                    state_d = EXEC;
            end
            EXEC: begin
                if (!i_hold) begin
                    o_commit = 1'b1;
`ifdef PC_MISALIGN_EN
                    if (misalign_hit) begin
                        state_d = TRAP;
                    end else begin
                        o_taken = redirect;
                        pc_load = 1'b1;
                        state_d = FETCH;
                    end
`else
                    o_taken = redirect;
                    pc_load = 1'b1;
                    state_d = FETCH;
`endif
                end
            end
`ifdef PC_MISALIGN_EN
            TRAP:  state_d = TRAP;
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            br_cnt_q    <= '0;
            taken_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (pc_load) begin
                pc_q <= next_pc;
                // Statistics saturate so long runs never alias back to small counts.
                if (i_is_branch && br_cnt_q != '1)
                    br_cnt_q <= br_cnt_q + CNT_ONE;
                if (br_taken && taken_cnt_q != '1)
                    taken_cnt_q <= taken_cnt_q + CNT_ONE;
            end
        end
    end

    assign o_pc        = pc_q;
    assign o_pc_four   = pc_q + 32'd4;
    assign o_br_un     = ~i_funct3[1];
    assign o_br_cnt    = br_cnt_q;
    assign o_taken_cnt = taken_cnt_q;

endmodule
